// File: rtl/mips_bus_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mips_bus_pkg : shared types and lane helpers for mips_bus_master         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package mips_bus_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        DATA  = 3'd2,
        RESP  = 3'd3,
        ERR   = 3'd4
    } state_t;

    function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] k);
        case (size)
            SZ_BYTE: be_gen = 4'b0001 << k;
            SZ_HALF: be_gen = k[1] ? 4'b1100 : 4'b0011;
            default: be_gen = 4'b1111;
        endcase
    endfunction

    // Size 11 has no legal encoding, so it is reported as misaligned.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = addr_lo[0];
            SZ_WORD: misaligned = (addr_lo != 2'b00);
            default: misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] k, input logic uns);
        logic [31:0] sh;
        sh = word >> {k, 3'b000};
        case (size)
            SZ_BYTE: lane_extract = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            SZ_HALF: lane_extract = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: lane_extract = sh;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_lane_align.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mips_lane_align : little-endian byte-lane steering and load extension     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mips_lane_align
    import mips_bus_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  k_i,
    input  logic        uns_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  byteenable_o,
    output logic [31:0] writedata_o,
    output logic [31:0] rdata_o
);

    always_comb begin
        byteenable_o = be_gen(size_i, k_i);
        rdata_o      = lane_extract(rdata_i, size_i, k_i, uns_i);
        case (size_i)
            SZ_BYTE: writedata_o = {4{wdata_i[7:0]}};
            SZ_HALF: writedata_o = {2{wdata_i[15:0]}};
            default: writedata_o = wdata_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mips_bus_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mips_bus_master : Avalon-MM master arbitrating MIPS fetch/data channels  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mips_bus_master
    import mips_bus_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int TIMEOUT    = 255,
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic              d_unsigned,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ready,
    output logic [31:0]       d_rdata,
    output logic              bus_err,
    output logic [ADDR_W-1:0] err_addr,
    output logic              busy,
    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic              write,
    output logic [31:0]       writedata,
    output logic [3:0]        byteenable,
    input  logic              waitrequest,
    input  logic [31:0]       readdata
);

    localparam int            c_CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LIMIT = c_CNT_W'(TIMEOUT);

    state_t              state_q, state_d;
    logic                fetch_q, fetch_d;
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
    logic [c_CNT_W-1:0]  cnt_q, cnt_d;

    logic                w_pick_data;
    logic                w_active;
    logic [c_CNT_W-1:0]  w_cnt_inc;
    logic [3:0]          w_be;
    logic [31:0]         w_wd;
    logic [31:0]         w_ext;

    assign w_pick_data = d_req && (DATA_FIRST || !if_req);
    assign w_active    = (state_q == FETCH) || (state_q == DATA);
    assign w_cnt_inc   = cnt_q + c_CNT_W'(1);

    mips_lane_align u_lane_align (
        .size_i       (size_q),
        .k_i          (addr_q[1:0]),
        .uns_i        (uns_q),
        .wdata_i      (wdata_q),
        .rdata_i      (rdata_q),
        .byteenable_o (w_be),
        .writedata_o  (w_wd),
        .rdata_o      (w_ext)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_q    <= 1'b0;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_addr_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            fetch_q    <= fetch_d;
            we_q       <= we_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_addr_q <= err_addr_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_d    = fetch_q;
        we_d       = we_q;
        size_d     = size_q;
        uns_d      = uns_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_addr_d = err_addr_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    cnt_d = '0;
                    if (w_pick_data) begin
                        fetch_d = 1'b0;
                        we_d    = d_we;
                        size_d  = d_size;
                        uns_d   = d_unsigned;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        if (misaligned(d_size, d_addr[1:0])) begin
                            state_d    = ERR;
                            err_addr_d = d_addr;
                        end else begin
                            state_d = DATA;
                        end
                    end else begin
                        // Fetches reuse the word path of the lane aligner.
                        fetch_d = 1'b1;
                        we_d    = 1'b0;
                        size_d  = SZ_WORD;
                        uns_d   = 1'b1;
                        addr_d  = if_addr;
                        wdata_d = '0;
                        if (misaligned(SZ_WORD, if_addr[1:0])) begin
                            state_d    = ERR;
                            err_addr_d = if_addr;
                        end else begin
                            state_d = FETCH;
                        end
                    end
                end
            end
            FETCH, DATA: begin
                // Completion is checked first so it wins over a same-edge timeout.
                if (!waitrequest) begin
                    rdata_d = we_q ? 32'h0 : readdata;
                    state_d = RESP;
                end else if ((TIMEOUT != 0) && (w_cnt_inc == c_CNT_LIMIT)) begin
                    state_d    = ERR;
                    err_addr_d = addr_q;
                end else begin
                    cnt_d = w_cnt_inc;
                end
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign bus_err    = (state_q == ERR);
    assign err_addr   = err_addr_q;
    assign read       = w_active && !we_q;
    assign write      = w_active && we_q;
    assign address    = {addr_q[ADDR_W-1:2], 2'b00};
    assign byteenable = w_active ? w_be : 4'b0000;
    assign writedata  = write ? w_wd : 32'h0;
    assign if_ready   = (state_q == RESP) && fetch_q;
    assign d_ready    = (state_q == RESP) && !fetch_q;
    assign if_rdata   = if_ready ? rdata_q : 32'h0;
    assign d_rdata    = (d_ready && !we_q) ? w_ext : 32'h0;

endmodule
`default_nettype wire
